// File: rtl/wallace_tree_multiplier_8x8.sv
//==============================================================================
// Module   : wallace_tree_multiplier_8x8
// Brief    : 8x8 unsigned multiplier, Wallace-tree reduction, registered product
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wallace_ha (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b;
    assign o_cout = i_a & i_b;
endmodule

module wallace_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// 3:2 carry-save compressor across three 16-bit rows.
module wallace_csa (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [15:0] i_z,
    output logic [15:0] o_sum,
    output logic [15:0] o_carry
);
    logic [14:0] w_cout;

    for (genvar b = 0; b < 15; b++) begin : g_bit
        wallace_fa u_fa (
            .i_a   (i_x[b]),
            .i_b   (i_y[b]),
            .i_cin (i_z[b]),
            .o_sum (o_sum[b]),
            .o_cout(w_cout[b])
        );
    end

    // Carry out of the top column has weight 2^16 and is always zero for 8x8.
    assign o_sum[15] = i_x[15] ^ i_y[15] ^ i_z[15];
    assign o_carry   = {w_cout, 1'b0};
endmodule

module wallace_tree_multiplier_8x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P
);
    logic [15:0] w_pp [8];
    logic [15:0] w_s1 [6];
    logic [15:0] w_s2 [4];
    logic [15:0] w_s3 [3];
    logic [15:0] w_s4 [2];
    logic [14:0] w_c;
    logic [15:0] w_prod;
    logic [15:0] r_p;

    for (genvar i = 0; i < 8; i++) begin : g_pp
        assign w_pp[i] = 16'(A & {8{B[i]}}) << i;
    end

    // Stage 1: 8 -> 6
    wallace_csa u_s1a (.i_x(w_pp[0]), .i_y(w_pp[1]), .i_z(w_pp[2]),
                       .o_sum(w_s1[0]), .o_carry(w_s1[1]));
    wallace_csa u_s1b (.i_x(w_pp[3]), .i_y(w_pp[4]), .i_z(w_pp[5]),
                       .o_sum(w_s1[2]), .o_carry(w_s1[3]));
    assign w_s1[4] = w_pp[6];
    assign w_s1[5] = w_pp[7];

    // Stage 2: 6 -> 4
    wallace_csa u_s2a (.i_x(w_s1[0]), .i_y(w_s1[1]), .i_z(w_s1[2]),
                       .o_sum(w_s2[0]), .o_carry(w_s2[1]));
    wallace_csa u_s2b (.i_x(w_s1[3]), .i_y(w_s1[4]), .i_z(w_s1[5]),
                       .o_sum(w_s2[2]), .o_carry(w_s2[3]));

    // Stage 3: 4 -> 3
    wallace_csa u_s3a (.i_x(w_s2[0]), .i_y(w_s2[1]), .i_z(w_s2[2]),
                       .o_sum(w_s3[0]), .o_carry(w_s3[1]));
    assign w_s3[2] = w_s2[3];

    // Stage 4: 3 -> 2
    wallace_csa u_s4a (.i_x(w_s3[0]), .i_y(w_s3[1]), .i_z(w_s3[2]),
                       .o_sum(w_s4[0]), .o_carry(w_s4[1]));

    // Final ripple-carry adder.
    wallace_ha u_cpa0 (
        .i_a   (w_s4[0][0]),
        .i_b   (w_s4[1][0]),
        .o_sum (w_prod[0]),
        .o_cout(w_c[0])
    );

    for (genvar b = 1; b < 15; b++) begin : g_cpa
        wallace_fa u_fa (
            .i_a   (w_s4[0][b]),
            .i_b   (w_s4[1][b]),
            .i_cin (w_c[b-1]),
            .o_sum (w_prod[b]),
            .o_cout(w_c[b])
        );
    end

    assign w_prod[15] = w_s4[0][15] ^ w_s4[1][15] ^ w_c[14];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= 16'h0000;
        end else begin
            r_p <= w_prod;
        end
    end

    assign P = r_p;
endmodule

`default_nettype wire

// File: tb/tb_wallace_tree_multiplier_8x8.sv
//==============================================================================
// Module   : tb_wallace_tree_multiplier_8x8
// Brief    : Directed self-checking bench for wallace_tree_multiplier_8x8
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wallace_tree_multiplier_8x8;
    logic        clk;
    logic        rst_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;

    int checks;
    int failures;

    wallace_tree_multiplier_8x8 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .P    (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        A = 8'd5;
        B = 8'd7;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (P !== 16'h0000) begin
            failures++;
            $display("FAIL reset_immediate: got %h expected 0000", P);
        end
        tick();
        tick();
        checks++;
        if (P !== 16'h0000) begin
            failures++;
            $display("FAIL reset_held: got %h expected 0000", P);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (P !== 16'd35) begin
            failures++;
            $display("FAIL reset_first_load: got %0d expected 35", P);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  va [5];
        logic [7:0]  vb [5];
        logic [15:0] ve [5];
        va = '{8'd0,   8'd255,    8'd128,   8'd1,     8'd12};
        vb = '{8'd200, 8'd255,    8'd2,     8'd173,   8'd0};
        ve = '{16'd0,  16'd65025, 16'd256,  16'd173,  16'd0};
        for (int k = 0; k < 5; k++) begin
            A = va[k];
            B = vb[k];
            tick();
            checks++;
            if (P !== ve[k]) begin
                failures++;
                $display("FAIL corner_%0d: A=%0d B=%0d got %0d expected %0d",
                         k, va[k], vb[k], P, ve[k]);
            end
        end
        A = 8'd255;
        B = 8'd255;
        tick();
        checks++;
        if (P !== 16'hFE01) begin
            failures++;
            $display("FAIL corner_max_hex: got %h expected fe01", P);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] ve [3];
        va = '{8'd3,  8'd17,  8'd255};
        vb = '{8'd5,  8'd15,  8'd1};
        ve = '{16'd15, 16'd255, 16'd255};
        for (int k = 0; k < 3; k++) begin
            A = va[k];
            B = vb[k];
            tick();
            checks++;
            if (P !== ve[k]) begin
                failures++;
                $display("FAIL back_to_back_%0d: got %0d expected %0d", k, P, ve[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        A = 8'd255;
        B = 8'd255;
        tick();
        checks++;
        if (P !== 16'd65025) begin
            failures++;
            $display("FAIL async_preload: got %0d expected 65025", P);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (P !== 16'h0000) begin
            failures++;
            $display("FAIL async_clear: got %0d expected 0", P);
        end
        tick();
        tick();
        checks++;
        if (P !== 16'h0000) begin
            failures++;
            $display("FAIL async_hold_low: got %0d expected 0", P);
        end
    endtask

    task automatic test_reset_release();
        A = 8'd12;
        B = 8'd12;
        rst_n = 1'b1;
        #2;
        checks++;
        if (P !== 16'h0000) begin
            failures++;
            $display("FAIL release_before_edge: got %0d expected 0", P);
        end
        tick();
        checks++;
        if (P !== 16'd144) begin
            failures++;
            $display("FAIL release_first_edge: got %0d expected 144", P);
        end
    endtask

    task automatic test_hold();
        A = 8'd100;
        B = 8'd3;
        tick();
        checks++;
        if (P !== 16'd300) begin
            failures++;
            $display("FAIL hold_load: got %0d expected 300", P);
        end
        A = 8'd7;
        B = 8'd9;
        #2;
        checks++;
        if (P !== 16'd300) begin
            failures++;
            $display("FAIL hold_change1: got %0d expected 300", P);
        end
        A = 8'd200;
        B = 8'd200;
        #2;
        checks++;
        if (P !== 16'd300) begin
            failures++;
            $display("FAIL hold_change2: got %0d expected 300", P);
        end
        tick();
        checks++;
        if (P !== 16'd40000) begin
            failures++;
            $display("FAIL hold_next_edge: got %0d expected 40000", P);
        end
    endtask

    task automatic test_sweep();
        int          sweep_errs;
        logic [15:0] exp;
        sweep_errs = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                A = 8'(a);
                B = 8'(b);
                exp = 16'(a * b);
                tick();
                checks++;
                if (P !== exp) begin
                    failures++;
                    sweep_errs++;
                    if (sweep_errs <= 10)
                        $display("FAIL sweep: A=%0d B=%0d got %0d expected %0d",
                                 a, b, P, exp);
                end
            end
        end
        $display("sweep errors: %0d", sweep_errs);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_corners();
        test_back_to_back();
        test_async_reset();
        test_reset_release();
        test_hold();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/wallace_tree_multiplier_8x8.md
WALLACE_TREE_MULTIPLIER_8X8 -- requirements
Module: wallace_tree_multiplier_8x8

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  8  multiplicand, unsigned.
REQ-005 B  input  8  multiplier, unsigned.
REQ-006 P  output  16  product A*B, unsigned, registered.
REQ-007 The block SHALL have one clock; its reset SHALL be asynchronous and active-low.

Function
REQ-008 The block SHALL compute the full unsigned product P = A*B; 16 bits, no truncation, no overflow possible (max 255*255 = 65025).
REQ-009 Partial products SHALL be formed as 64 AND terms pp[i][j] = A[j] & B[i], weight 2^(i+j).
REQ-010 Partial-product reduction SHALL be a Wallace tree:
- each stage groups rows in threes through full adders (3:2) and half adders (2:2);
- leftover rows pass through unchanged;
- reduction repeats until exactly two rows remain (4 stages for 8 rows: 8->6->4->3->2).
REQ-011 The two final rows SHALL be summed by a 16-bit carry-propagate adder (ripple acceptable); its carry-out beyond bit 15 is always 0 and SHALL be discarded.
REQ-012 The arithmetic path SHALL be built from explicit half-adder/full-adder cells; no behavioural multiply operator.
REQ-013 The tree and final adder SHALL be purely combinational; only the output register holds state.
REQ-014 Latency: P SHALL equal A*B sampled at rising edge n, and SHALL be visible after edge n.
REQ-015 Throughput: one new operand pair SHALL be accepted every cycle, with no stall or handshake.
REQ-016 P SHALL stay constant between rising edges regardless of input changes.
REQ-017 Operand boundaries SHALL be exact:
- A=0 or B=0 gives 0;
- A=1 gives B;
- A=B=255 gives 16'hFE01.
REQ-018 P SHALL never contain X or Z once reset has been applied and inputs are known.

Reset
REQ-019 While rst_n=0, P SHALL be forced to 16'h0000 immediately, without waiting for clk.
REQ-020 Reset asserted mid-stream SHALL discard the pending product; P stays 0 until the first rising edge after rst_n deasserts.
REQ-021 After rst_n deasserts, the first rising edge SHALL load the product of the A/B values present at that edge.
REQ-022 The combinational tree SHALL need no reset.

Verification
REQ-023 Exhaustive sweep: all 65536 (A,B) pairs, one per cycle. Each P, one cycle later, SHALL match the golden A*B; zero mismatches, with the error count reported.
REQ-024 Corner cases, one cycle later:
- A=0,B=200 -> 0;
- A=255,B=255 -> 65025;
- A=128,B=2 -> 256;
- A=1,B=173 -> 173.
REQ-025 Back-to-back pipelining: drive (3,5),(17,15),(255,1) on consecutive cycles. P SHALL show 15,255,255 on consecutive cycles.
REQ-026 Asynchronous reset: with P=65025, drop rst_n between edges. P SHALL be 0 before the next clk edge and remain 0 while rst_n=0.
REQ-027 Reset release: deassert rst_n with A=12,B=12 held. P SHALL stay 0 until the next rising edge, then become 144.
REQ-028 Hold: change A/B between edges without a clock edge. P SHALL be unchanged until the next rising edge.
